// File: rtl/mmu_pkg.sv
// Shared types for the MMU data port: func3 codes, FIFO entry layout, FSM states
// and the access-size/alignment helpers used by the FIFO head and the lane logic.
package mmu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef struct packed {
      logic        we;
      logic [4:0]  rtag;
      logic [2:0]  func3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mmu_req_t;

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, RESP} mmu_state_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mmu_size_e;

   // Unlisted func3 codes fall through to word size.
   function automatic mmu_size_e req_size(input mmu_req_t r);
      mmu_size_e sz;
      sz = SZ_W;
      if (r.func3 == SB || (!r.we && r.func3 == LBU))      sz = SZ_B;
      else if (r.func3 == SH || (!r.we && r.func3 == LHU)) sz = SZ_H;
      return sz;
   endfunction

   function automatic logic req_misaligned(input mmu_req_t r);
      mmu_size_e sz;
      sz = req_size(r);
      return (sz == SZ_H && r.addr[0]) || (sz == SZ_W && r.addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/mmu_req_fifo.sv
// In-order request FIFO: two pushes per cycle (port a lands ahead of port b), one pop.
module mmu_req_fifo
   import mmu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      cpu_clk_aon,
   input  logic                      i_rstn,
   input  logic                      push_a,
   input  mmu_req_t                  din_a,
   input  logic                      push_b,
   input  mmu_req_t                  din_b,
   input  logic                      pop,
   output mmu_req_t                  head,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    free
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   mmu_req_t      mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          do_a, do_b, do_pop;

   assign free   = DEPTH_W - cnt;
   assign full   = (cnt == DEPTH_W);
   assign empty  = (cnt == '0);
   assign head   = mem[rptr];
   assign do_a   = push_a && !full;
   assign do_b   = push_b && (free > (AW+1)'(do_a));
   assign do_pop = pop && !empty;

   always_ff @(posedge cpu_clk_aon) begin
      if (do_a) mem[wptr] <= din_a;
      if (do_b) mem[wptr + AW'(do_a)] <= din_b;
   end

   always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         wptr <= wptr + AW'(do_a) + AW'(do_b);
         rptr <= rptr + AW'(do_pop);
         cnt  <= cnt + (AW+1)'(do_a) + (AW+1)'(do_b) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/mmu_data_port.sv
// Load/store responder: queues requests, issues one memory access at a time and
// returns lane-aligned load data or a store acknowledge, strictly in request order.
module mmu_data_port
   import mmu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        cpu_clk_aon,
   input  logic        i_rstn,
   input  logic        mmu_rd_req,
   input  logic [4:0]  mmu_rd_req_reg,
   input  logic [2:0]  mmu_rd_req_func3,
   input  logic [31:0] mmu_rd_addr,
   input  logic        mmu_wr_req,
   input  logic [4:0]  mmu_wr_req_reg,
   input  logic [2:0]  mmu_wr_req_func3,
   input  logic [31:0] mmu_wr_addr,
   input  logic [31:0] mmu_wr_data,
   output logic        mmu_rd_valid,
   output logic [4:0]  mmu_rd_valid_reg,
   output logic [2:0]  mmu_rd_valid_func3,
   output logic [31:0] mmu_rd_data,
   output logic        mmu_wr_done,
   output logic [4:0]  mmu_wr_done_reg,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        mmu_full,
   output logic [1:0]  mmu_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   mmu_state_e  state;
   mmu_req_t    wr_ent, rd_ent, head;
   logic        fifo_full, fifo_empty, head_mis, pop, acc_wr, acc_rd;
   logic [AW:0] free, nxt_free;
   logic        cur_we;
   logic [4:0]  cur_tag;
   logic [2:0]  cur_func3;
   logic [1:0]  cur_lane;

   assign wr_ent = '{we: 1'b1, rtag: mmu_wr_req_reg, func3: mmu_wr_req_func3,
                     addr: mmu_wr_addr, wdata: mmu_wr_data};
   assign rd_ent = '{we: 1'b0, rtag: mmu_rd_req_reg, func3: mmu_rd_req_func3,
                     addr: mmu_rd_addr, wdata: 32'h0};

   // Store is pushed ahead of a same-cycle load; whatever does not fit is dropped.
   assign acc_wr   = mmu_wr_req && !fifo_full;
   assign acc_rd   = mmu_rd_req && (free > (AW+1)'(acc_wr));
   assign nxt_free = free - (AW+1)'(acc_wr) - (AW+1)'(acc_rd) + (AW+1)'(pop);

   mmu_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .cpu_clk_aon (cpu_clk_aon),
      .i_rstn      (i_rstn),
      .push_a      (mmu_wr_req),
      .din_a       (wr_ent),
      .push_b      (mmu_rd_req),
      .din_b       (rd_ent),
      .pop         (pop),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .free        (free)
   );

   assign head_mis = req_misaligned(head);
   assign mem_req  = (state == IDLE && !fifo_empty && !head_mis) || state == WAIT_GNT;
   assign pop      = (state == IDLE && !fifo_empty && (head_mis || mem_gnt)) ||
                     (state == WAIT_GNT && mem_gnt);
   assign mem_we   = mem_req && head.we;
   assign mem_addr = mem_req ? {head.addr[31:2], 2'b00} : 32'h0;

   always_comb begin
      mem_be    = 4'h0;
      mem_wdata = 32'h0;
      if (mem_req) begin
         unique case (req_size(head))
            SZ_B: begin
               mem_be    = 4'b0001 << head.addr[1:0];
               mem_wdata = {4{head.wdata[7:0]}};
            end
            SZ_H: begin
               mem_be    = 4'b0011 << head.addr[1:0];
               mem_wdata = {2{head.wdata[15:0]}};
            end
            default: begin
               mem_be    = 4'hF;
               mem_wdata = head.wdata;
            end
         endcase
         if (!head.we) mem_wdata = 32'h0;
      end
   end

   always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
      if (!i_rstn) begin
         state              <= IDLE;
         cur_we             <= 1'b0;
         cur_tag            <= '0;
         cur_func3          <= '0;
         cur_lane           <= '0;
         mmu_rd_valid       <= 1'b0;
         mmu_rd_valid_reg   <= '0;
         mmu_rd_valid_func3 <= '0;
         mmu_rd_data        <= '0;
         mmu_wr_done        <= 1'b0;
         mmu_wr_done_reg    <= '0;
         mmu_full           <= 1'b0;
         mmu_err            <= '0;
      end else begin
         mmu_rd_valid <= 1'b0;
         mmu_wr_done  <= 1'b0;
         mmu_full     <= nxt_free < (AW+1)'(2);
         if ((mmu_wr_req && !acc_wr) || (mmu_rd_req && !acc_rd)) mmu_err[0] <= 1'b1;
         unique case (state)
            IDLE: begin
               if (!fifo_empty && head_mis) begin
                  // Misaligned head completes without touching memory.
                  mmu_err[1]   <= 1'b1;
                  mmu_rd_valid <= !head.we;
                  mmu_wr_done  <= head.we;
                  if (head.we) mmu_wr_done_reg <= head.rtag;
                  else begin
                     mmu_rd_valid_reg   <= head.rtag;
                     mmu_rd_valid_func3 <= head.func3;
                     mmu_rd_data        <= 32'h0;
                  end
                  state <= RESP;
               end else if (!fifo_empty) begin
                  cur_we    <= head.we;
                  cur_tag   <= head.rtag;
                  cur_func3 <= head.func3;
                  cur_lane  <= head.addr[1:0];
                  state     <= mem_gnt ? WAIT_RSP : WAIT_GNT;
               end
            end
            WAIT_GNT: if (mem_gnt) state <= WAIT_RSP;
            WAIT_RSP: begin
               if (mem_rvalid) begin
                  mmu_rd_valid <= !cur_we;
                  mmu_wr_done  <= cur_we;
                  if (cur_we) mmu_wr_done_reg <= cur_tag;
                  else begin
                     mmu_rd_valid_reg   <= cur_tag;
                     mmu_rd_valid_func3 <= cur_func3;
                     mmu_rd_data        <= mem_rdata >> {cur_lane, 3'b000};
                  end
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mmu_data_port.md
# mmu_data_port

Load/store responder between the decode/execute stage and the data memory. It accepts single-cycle read and write request pulses (`mmu_rd_req`, `mmu_wr_req`) into an in-order request FIFO and issues one memory transaction at a time. Read data is returned lane-aligned with an `mmu_rd_valid` pulse; stores are acknowledged with an `mmu_wr_done` pulse. Sign/zero extension of load data stays in the decode stage; this block only shifts the addressed byte or halfword down to bit 0.

## Interface
Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.

Ports:
- cpu_clk_aon  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- mmu_rd_req  in  1  load request pulse, one per cycle max.
- mmu_rd_req_reg  in  5  destination register tag.
- mmu_rd_req_func3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- mmu_rd_addr  in  32  byte address.
- mmu_wr_req  in  1  store request pulse.
- mmu_wr_req_reg  in  5  tag echoed on completion.
- mmu_wr_req_func3  in  3  000 sb, 001 sh, 010 sw.
- mmu_wr_addr  in  32  byte address.
- mmu_wr_data  in  32  store data; the value is in the low bits.
- mmu_rd_valid  out  1  one-cycle load completion pulse.
- mmu_rd_valid_reg  out  5  tag of the completed load.
- mmu_rd_valid_func3  out  3  func3 of the completed load.
- mmu_rd_data  out  32  lane-aligned load data.
- mmu_wr_done  out  1  one-cycle store completion pulse.
- mmu_wr_done_reg  out  5  tag of the completed store.
- mem_req  out  1  memory request; held until `mem_gnt`.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, byte address with bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response; acknowledges both reads and writes.
- mem_rdata  in  32  read word.
- mmu_full  out  1  FIFO has fewer than 2 free entries.
- mmu_err  out  2  sticky: [0] overflow, [1] misaligned.

## Operation
- **FIFO entry contents:** {we, reg, func3, addr, wdata}.
- **Enqueue order:** simultaneous `mmu_wr_req` and `mmu_rd_req` push both in the same cycle, store first.
- **Overflow:** a push into a full FIFO drops that request and sets `mmu_err[0]`.
- **FSM IDLE:**
  - If the FIFO is non-empty and the head is misaligned (lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0): pop the head, issue no memory access, set `mmu_err[1]`, and go to RESP. A misaligned load completes with data 0; a misaligned store completes with `mmu_wr_done`.
  - Otherwise, if the FIFO is non-empty: drive `mem_req` combinationally from the head. With `mem_gnt`, pop and go to WAIT_RSP; without it, go to WAIT_GNT.
- **FSM WAIT_GNT:** keep `mem_req` and the head fields stable. On `mem_gnt`, pop and go to WAIT_RSP.
- **FSM WAIT_RSP:** the in-flight entry is held in a register. On `mem_rvalid`, capture the response and go to RESP.
- **FSM RESP:** drive the registered completion pulse (`mmu_rd_valid` or `mmu_wr_done`), then go to IDLE.
- **Load data:** `mmu_rd_data = mem_rdata >> (8*addr[1:0])`, zero-filled from the top.
- **Store byte enables and data:**
  - sb: be = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: be = 3<<addr[1:0]; wdata = {2{wdata[15:0]}}.
  - sw: be = 4'hF.
- **Unsupported func3:** any func3 not listed is treated as lw/sw.
- **Ignored inputs:** `mem_rvalid` outside WAIT_RSP is ignored.
- **Errors:** `mmu_err` clears only on reset.

## Timing
- **Reset values:** every output is 0, the FIFO is empty, the state is IDLE. Reset mid-transaction discards all queued and in-flight requests; `mem_req` drops asynchronously.
- **Enqueue:** a request pulse at cycle 0 is visible at the FIFO head in cycle 1.
- **Load latency, zero-wait memory** (`mem_gnt` with `mem_req`, `mem_rvalid` the next cycle):
  - `mem_req` in cycle 1.
  - `mem_rvalid` in cycle 2.
  - `mmu_rd_valid` in cycle 3.
  - Minimum request-to-completion latency is 3 cycles.
- **Throughput:** one access per 3 cycles with zero-wait memory. `mem_req` never reasserts in RESP.
- **Completion pulses:** `mmu_rd_valid` and `mmu_wr_done` are never high in the same cycle, and completions are in request order.
- **mmu_full:** registered; it reflects occupancy after the current cycle's push and pop.

## Structure
- **Shared package `mmu_pkg`:**
  - func3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The `mmu_req_t` packed struct for a FIFO entry.
  - FSM state enum: IDLE, WAIT_GNT, WAIT_RSP, RESP.
- **Sub-module `mmu_req_fifo`:** dual-push, single-pop FIFO parameterised on depth, with full/empty/free-count outputs.
- **Top level:** the FSM, lane logic and error flags.

## Test plan
- **Aligned lw:** lw addr 0x100, reg 5; memory returns 0xDEADBEEF with zero wait → `mmu_rd_valid` in cycle 3 with reg 5, func3 010, data 0xDEADBEEF.
- **lbu lane shift:** lbu addr 0x103, mem word 0xAABBCCDD → `mem_addr` 0x100, `mmu_rd_data` 0x000000AA.
- **sh lane placement:** sh addr 0x202, data 0x1234, reg 7 → `mem_be` 4'b1100, `mem_wdata` 0x12341234, then `mmu_wr_done` with reg 7.
- **Simultaneous requests:** wr 0x10 and rd 0x20 in the same cycle → `mem_we` = 1 access issued first; `mmu_wr_done` precedes `mmu_rd_valid`.
- **Overflow and misalignment:**
  - Hold `mem_gnt` = 0 and send 5 loads with FIFO_DEPTH = 4 → `mmu_full` asserts, the 5th load is dropped, `mmu_err[0]` = 1, and the 4 queued loads complete in order.
  - lw addr 0x102 → no `mem_req`, `mmu_rd_valid` with data 0, `mmu_err[1]` = 1.
- **Reset mid-transaction:** assert `i_rstn` low during WAIT_RSP → outputs go to 0 immediately; after release, a stale `mem_rvalid` produces no pulse.
